// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush controller for the 5-stage in-order RV32 pipeline.
// Define HAZARD_CTRL_PERF_EN to add the perf_stall_cycles / perf_flush_events counters.
module hazard_ctrl #(
   parameter int MC_MAX_CYCLES = 34
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        ex_mc_start,
   input  logic        mc_done,
   input  logic        imem_ready,
   input  logic        mem_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        stall_ifid,
   output logic        stall_idex,
   output logic        stall_exmem,
   output logic        stall_memwb,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exmem,
   output logic        flush_memwb,
   output logic        mc_timeout,
`ifdef HAZARD_CTRL_PERF_EN
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_events,
`endif
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MC_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   // Counter value seen in the last allowed cycle; the start cycle counts as 1.
   localparam logic [7:0] WD_LIMIT = 8'(MC_MAX_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_mc_pend;
   logic        r_done_pend;
   logic        r_timeout;
   logic [7:0]  r_wd_cnt;

   logic        w_mem_stall;
   logic        w_load_use;
   logic        w_rs1_hit;
   logic        w_rs2_hit;
   logic        w_in_run;
   logic        w_redirect;
   logic        w_done_any;
   logic        w_wd_expire;
   logic        w_release;
   logic        w_mc_start_hold;
   logic        w_mc_enter;
   logic        w_mc_hold;

   // Hazard detection
   assign w_mem_stall = mem_req & ~dmem_ready;
   assign w_rs1_hit   = id_rs1_used & (id_rs1 == ex_rd);
   assign w_rs2_hit   = id_rs2_used & (id_rs2 == ex_rd);
   assign w_load_use  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
   assign w_in_run    = (r_state == RUN);
   assign w_redirect  = ex_redirect & ~ex_mc_start;

   // Multi-cycle tracking: r_mc_pend covers both MC_WAIT and a MEM_WAIT that interrupted it.
   assign w_done_any      = mc_done | r_done_pend;
   assign w_wd_expire     = r_mc_pend & (r_wd_cnt >= WD_LIMIT);
   assign w_release       = r_mc_pend & ~w_mem_stall & (w_done_any | w_wd_expire);
   assign w_mc_start_hold = w_in_run & ex_mc_start & ~mc_done;
   assign w_mc_enter      = w_mc_start_hold & ~w_mem_stall;
   assign w_mc_hold       = w_mc_start_hold | (r_mc_pend & ~w_release);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               w_state_nxt = MEM_WAIT;
            end else if (w_mc_start_hold) begin
               w_state_nxt = MC_WAIT;
            end
         end
         MC_WAIT: begin
            if (w_mem_stall) begin
               w_state_nxt = MEM_WAIT;
            end else if (w_release) begin
               w_state_nxt = RUN;
            end
         end
         MEM_WAIT: begin
            if (!w_mem_stall) begin
               w_state_nxt = (r_mc_pend & ~w_release) ? MC_WAIT : RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RUN;
         r_mc_pend   <= 1'b0;
         r_done_pend <= 1'b0;
         r_wd_cnt    <= 8'd0;
         r_timeout   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_release) begin
            r_mc_pend <= 1'b0;
         end else if (w_mc_enter) begin
            r_mc_pend <= 1'b1;
         end

         if (w_release) begin
            r_done_pend <= 1'b0;
         end else if (mc_done & w_mem_stall & r_mc_pend) begin
            r_done_pend <= 1'b1;
         end

         // Saturates so a long memory stall cannot wrap past the limit.
         if (w_release | ~r_mc_pend) begin
            r_wd_cnt <= w_mc_enter ? 8'd1 : 8'd0;
         end else if (r_wd_cnt != 8'hFF) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
         end

         if (w_release & ~w_done_any) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Priority-ordered Mealy outputs
   always_comb begin
      pc_en       = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      stall_memwb = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      flush_memwb = 1'b0;
      if (reset) begin
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
         flush_memwb = 1'b1;
      end else if (w_mem_stall) begin
         stall_ifid  = 1'b1;
         stall_idex  = 1'b1;
         stall_exmem = 1'b1;
         stall_memwb = 1'b1;
      end else if (w_mc_hold) begin
         stall_ifid  = 1'b1;
         stall_idex  = 1'b1;
         flush_exmem = 1'b1;
      end else if (w_in_run & w_redirect) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         pc_en      = 1'b1;
      end else if (w_in_run & w_load_use) begin
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (w_in_run & ~imem_ready) begin
         flush_ifid = 1'b1;
      end else begin
         pc_en = 1'b1;
      end
   end

   assign state      = reset ? RUN : r_state;
   assign mc_timeout = r_timeout & ~reset;

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_stall <= 32'd0;
         r_perf_flush <= 32'd0;
      end else begin
         if (!pc_en) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (flush_idex) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
      end
   end

   assign perf_stall_cycles = r_perf_stall;
   assign perf_flush_events = r_perf_flush;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush controller for the 5-stage in-order single-issue RV32 core; drives the `stall`/`flush` inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. Detects load-use hazards, EX-stage redirects, instruction/data memory wait states and multi-cycle EX operations. Tracks multi-cycle operations with a small FSM and a watchdog counter. Outputs are Mealy: a hazard is resolved in the same cycle it is presented.

## Interface
- `MC_MAX_CYCLES`, 34, watchdog limit in MC_WAIT cycles, including the start cycle; legal range 2..255.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1  the corresponding source is read.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_rd`  in  5  EX destination register.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  the EX branch or jump redirects the PC.
- `ex_mc_start`  in  1  the EX instruction is multi-cycle (mul/div).
- `mc_done`  in  1  one-cycle pulse: the multi-cycle result is ready.
- `imem_ready`  in  1  fetch data is valid this cycle.
- `mem_req`, `dmem_ready`  in  1  MEM-stage access pending, and its completion.
- `pc_en`  out  1  the PC register updates.
- `stall_ifid`, `stall_idex`, `stall_exmem`, `stall_memwb`  out  1 each  hold the corresponding pipe.
- `flush_ifid`, `flush_idex`, `flush_exmem`, `flush_memwb`  out  1 each  bubble the corresponding pipe.
- `mc_timeout`  out  1  sticky; set when the watchdog expires.
- `state`  out  2  FSM state for debug: RUN=0, MC_WAIT=1, MEM_WAIT=2.

## Operation
- Pipe semantics: a flush zeroes the pipe and takes priority over stall; a stall holds the pipe.
- `mem_stall = mem_req & ~dmem_ready`.
- `load_use = ex_valid & ex_mem_read & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Priority, highest first; each cycle only the first matching row drives outputs. Every output not named is 0.
  1. `mem_stall`, any state: all four stalls = 1, `pc_en` = 0, no flush.
  2. MC hold: state RUN with `ex_mc_start & ~mc_done`, or state MC_WAIT without release. Drives `stall_ifid`, `stall_idex`; `flush_exmem` = 1; `pc_en` = 0.
  3. `ex_redirect`, RUN only: `flush_ifid` = 1, `flush_idex` = 1, `pc_en` = 1.
  4. `load_use`, RUN only: `stall_ifid` = 1, `flush_idex` = 1, `pc_en` = 0.
  5. `~imem_ready`, RUN only: `flush_ifid` = 1, `pc_en` = 0.
  6. Otherwise: `pc_en` = 1.
- In MC_WAIT and MEM_WAIT, `ex_redirect` and `load_use` are ignored. The instructions that raised them are held and re-evaluated on return to RUN.
- FSM:
  - RUN→MEM_WAIT on `mem_stall`.
  - RUN→MC_WAIT on `ex_mc_start & ~mc_done` (without `mem_stall`).
  - MEM_WAIT→MC_WAIT when `mem_stall` = 0 and an MC operation is outstanding (`mc_pend` = 1); otherwise MEM_WAIT→RUN.
  - MC_WAIT→RUN on release. MC_WAIT→MEM_WAIT on `mem_stall`.
- `mc_pend` flag: set on entry to MC_WAIT; cleared on release.
- `done_pend` flag: set when `mc_done` arrives during `mem_stall`. MC release occurs in the first non-`mem_stall` cycle with `mc_done | done_pend`; `done_pend` clears at that release.
- Watchdog counter, 8 bits:
  - Cleared in RUN; increments in every MC_WAIT or MEM_WAIT cycle while `mc_pend` = 1.
  - On reaching `MC_MAX_CYCLES-1` without done, it forces a release and sets `mc_timeout`.
  - `mc_timeout` clears only on reset.
- `ex_redirect` and `ex_mc_start` asserted together is illegal; `ex_mc_start` wins.

## Timing
- Outputs are combinational from state, flags and inputs: zero-cycle hazard response.
- While `reset` = 1:
  - Outputs: all flushes = 1, all stalls = 0, `pc_en` = 0, `state` = RUN, `mc_timeout` = 0.
  - Internal: counter, `mc_pend` and `done_pend` cleared.
- Reset mid-MC_WAIT or mid-MEM_WAIT: RUN on the next edge, with no pending release.
- Load-use costs exactly 1 bubble. A redirect costs 2 squashed instructions.
- Multi-cycle op with done N cycles after start: N stall cycles. If `mc_done` arrives in the start cycle, there is no stall.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined adds two outputs, both cleared by reset and wrapping at 2^32:
  - `perf_stall_cycles` (32): counts cycles with `pc_en` = 0 and `reset` = 0.
  - `perf_flush_events` (32): counts cycles in which `flush_idex` = 1 with `reset` = 0.
- Undefined: the two ports and their counters are absent; all other behaviour is identical.

## Test plan
- Load-use: `ex_valid`=1, `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_used`=1 → same cycle `pc_en`=0, `stall_ifid`=1, `flush_idex`=1. With `ex_rd`=0 → `pc_en`=1 and no flush.
- Redirect plus load-use plus `imem_ready`=0 in the same cycle → `flush_ifid`=1, `flush_idex`=1, `pc_en`=1, `stall_ifid`=0.
- `ex_mc_start` then `mc_done` 3 cycles later → `state` 0→1; 3 cycles with `stall_ifid`=`stall_idex`=`flush_exmem`=1; in the done cycle all outputs are 0 and `pc_en`=1; next cycle `state`=0.
- `mc_done` during a 2-cycle `mem_stall` in MC_WAIT → all stalls =1 for 2 cycles, `state`=2; release in the next cycle; `mc_timeout`=0.
- `MC_MAX_CYCLES`=4 with no `mc_done` → release in the 4th cycle, `mc_timeout`=1 and it stays 1 until reset.
- `reset` asserted in the 2nd MC_WAIT cycle → all flushes =1, `pc_en`=0; after deassert `state`=0; a later `mc_done` has no effect.
